// File: rtl/vna_scanner_mc.sv
// VNA scan sequencer: steps the Tx/Rx NCO word per point, waits out the settle time,
// then averages 2**AVG_LOG2 valid cordic samples per channel into one fixed-rate output slot.
module vna_scanner_mc #(
    parameter int NCH             = 2,
    parameter int IN_W            = 18,
    parameter int OUT_W           = 24,
    parameter int AVG_LOG2        = 10,
    parameter int CLKS_PER_SAMPLE = 9600,
    parameter int SETTLE_CLKS     = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vna,
    input  logic                 scan_start,
    input  logic                 continuous,
    input  logic [31:0]          freq_start,
    input  logic [31:0]          freq_delta,
    input  logic [31:0]          rx_freq_in,
    input  logic [15:0]          vna_count,
    input  logic                 in_valid,
    input  logic [NCH*IN_W-1:0]  cordic_data_I,
    input  logic [NCH*IN_W-1:0]  cordic_data_Q,
    output logic [31:0]          tx_freq,
    output logic [31:0]          rx_phase,
    output logic [1:0]           tx_zero,
    output logic                 output_strobe,
    output logic [NCH*OUT_W-1:0] out_data_I,
    output logic [NCH*OUT_W-1:0] out_data_Q,
    output logic [15:0]          out_index,
    output logic                 out_marker,
    output logic                 out_short,
    output logic                 scan_done
);
    localparam int ACC_W = IN_W + AVG_LOG2;
    localparam int CNT_W = $clog2(CLKS_PER_SAMPLE);
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(SETTLE_CLKS);
    localparam logic [SMP_W-1:0] SMP_FULL  = {1'b1, {AVG_LOG2{1'b0}}};

    typedef enum logic [2:0] {IDLE, PC_SCAN, STARTUP, SLOT, HOLD} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]        slot_cnt;
    logic [15:0]             pt_idx, pt_idx_nxt, sh_count;
    logic [31:0]             sh_start, sh_delta, tx_nxt, rx_nxt;
    logic [SMP_W-1:0]        smp_cnt, smp_nxt;
    logic                    slot_end, last_pt, sample_en, start_slot, load_sh, emit;
    logic signed [ACC_W-1:0] acc_i_p0 [NCH];
    logic signed [ACC_W-1:0] acc_q_p0 [NCH];
    logic signed [ACC_W-1:0] acc_i_nxt [NCH];
    logic signed [ACC_W-1:0] acc_q_nxt [NCH];

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] x);
        return ACC_W'(x);
    endfunction

    // Truncating divide by 2**(ACC_W-OUT_W): keep the top OUT_W bits.
    function automatic logic [OUT_W-1:0] trunc_out(input logic signed [ACC_W-1:0] a);
        return a[ACC_W-1 -: OUT_W];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        slot_end   = (state == SLOT) && (slot_cnt == SLOT_LAST);
        last_pt    = (pt_idx == sh_count);
        sample_en  = (state == SLOT) && (slot_cnt >= SETTLE) && in_valid && (smp_cnt < SMP_FULL);
        smp_nxt    = smp_cnt + SMP_W'(sample_en);
        emit       = vna && slot_end;
        for (int c = 0; c < NCH; c++) begin
            acc_i_nxt[c] = acc_i_p0[c] + (sample_en ? sext(cordic_data_I[c*IN_W +: IN_W]) : '0);
            acc_q_nxt[c] = acc_q_p0[c] + (sample_en ? sext(cordic_data_Q[c*IN_W +: IN_W]) : '0);
        end

        state_nxt  = state;
        tx_nxt     = tx_freq;
        rx_nxt     = rx_phase;
        pt_idx_nxt = pt_idx;
        start_slot = 1'b0;
        load_sh    = 1'b0;
        if (!vna) begin
            state_nxt = IDLE;
            tx_nxt    = freq_start;
            rx_nxt    = rx_freq_in;
        end else begin
            unique case (state)
                IDLE, HOLD: begin
                    if (vna_count == 16'd0) begin
                        state_nxt = PC_SCAN;
                    end else if (continuous || scan_start) begin
                        state_nxt = STARTUP;
                        tx_nxt    = '0;
                        rx_nxt    = '0;
                    end
                end
                PC_SCAN: begin
                    tx_nxt = freq_start;
                    rx_nxt = freq_start;
                    if (vna_count != 16'd0) state_nxt = IDLE;
                end
                STARTUP: begin
                    state_nxt  = SLOT;
                    load_sh    = 1'b1;
                    start_slot = 1'b1;
                    pt_idx_nxt = '0;
                    tx_nxt     = freq_start;
                    rx_nxt     = freq_start;
                end
                SLOT: begin
                    if (slot_end) begin
                        start_slot = 1'b1;
                        if (last_pt) begin
                            pt_idx_nxt = '0;
                            // Back-to-back restart skips STARTUP, so the NCO phase is not re-zeroed.
                            if (continuous) begin
                                load_sh = 1'b1;
                                tx_nxt  = freq_start;
                                rx_nxt  = freq_start;
                            end else begin
                                state_nxt = HOLD;
                            end
                        end else begin
                            pt_idx_nxt = pt_idx + 16'd1;
                            tx_nxt     = (pt_idx == 16'd0) ? sh_start : tx_freq + sh_delta;
                            rx_nxt     = tx_nxt;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p0: accumulate; result registered on the slot's last clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_freq       <= '0;
            rx_phase      <= '0;
            tx_zero       <= '0;
            output_strobe <= 1'b0;
            scan_done     <= 1'b0;
            out_data_I    <= '0;
            out_data_Q    <= '0;
            out_index     <= '0;
            out_marker    <= 1'b0;
            out_short     <= 1'b0;
            pt_idx        <= '0;
            slot_cnt      <= '0;
            smp_cnt       <= '0;
            sh_start      <= '0;
            sh_delta      <= '0;
            sh_count      <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_i_p0[c] <= '0;
                acc_q_p0[c] <= '0;
            end
        end else begin
            tx_freq       <= tx_nxt;
            rx_phase      <= rx_nxt;
            tx_zero       <= {tx_nxt[31:16] == 16'd0, tx_nxt[15:0] == 16'd0};
            pt_idx        <= pt_idx_nxt;
            output_strobe <= emit;
            scan_done     <= emit && last_pt;
            if (load_sh) begin
                sh_start <= freq_start;
                sh_delta <= freq_delta;
                sh_count <= vna_count;
            end
            if (start_slot || !vna) begin
                slot_cnt <= '0;
                smp_cnt  <= '0;
                for (int c = 0; c < NCH; c++) begin
                    acc_i_p0[c] <= '0;
                    acc_q_p0[c] <= '0;
                end
            end else if (state == SLOT) begin
                slot_cnt <= slot_cnt + CNT_W'(1);
                smp_cnt  <= smp_nxt;
                for (int c = 0; c < NCH; c++) begin
                    acc_i_p0[c] <= acc_i_nxt[c];
                    acc_q_p0[c] <= acc_q_nxt[c];
                end
            end
            if (emit) begin
                out_index  <= pt_idx;
                out_marker <= (pt_idx == 16'd0);
                out_short  <= (pt_idx != 16'd0) && (smp_nxt < SMP_FULL);
                for (int c = 0; c < NCH; c++) begin
                    out_data_I[c*OUT_W +: OUT_W] <= (pt_idx == 16'd0) ? '0 : trunc_out(acc_i_nxt[c]);
                    out_data_Q[c*OUT_W +: OUT_W] <= (pt_idx == 16'd0) ? '0 : trunc_out(acc_q_nxt[c]);
                end
            end
        end
    end
endmodule

// File: tb/tb_vna_scanner_mc.sv
// Scoreboard bench for vna_scanner_mc: scans are predicted point by point from the scan rules
// and a monitor compares every output strobe against the queued prediction.
`timescale 1ns/1ps
module tb_vna_scanner_mc;
    localparam int NCH      = 2;
    localparam int IN_W     = 18;
    localparam int OUT_W    = 24;
    localparam int AVG_LOG2 = 8;
    localparam int CLKS     = 512;
    localparam int SETTLE   = 128;
    localparam int WINDOW   = CLKS - SETTLE;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int SHIFT    = IN_W + AVG_LOG2 - OUT_W;

    logic clk = 1'b0;
    logic rst_n, vna, scan_start, continuous, in_valid;
    logic [31:0] freq_start, freq_delta, rx_freq_in, tx_freq, rx_phase;
    logic [15:0] vna_count, out_index;
    logic [NCH*IN_W-1:0]  cordic_data_I, cordic_data_Q;
    logic [NCH*OUT_W-1:0] out_data_I, out_data_Q;
    logic [1:0] tx_zero;
    logic output_strobe, out_marker, out_short, scan_done;

    always #5 clk = ~clk;

    vna_scanner_mc #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2),
                     .CLKS_PER_SAMPLE(CLKS), .SETTLE_CLKS(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .vna(vna), .scan_start(scan_start), .continuous(continuous),
        .freq_start(freq_start), .freq_delta(freq_delta), .rx_freq_in(rx_freq_in),
        .vna_count(vna_count), .in_valid(in_valid), .cordic_data_I(cordic_data_I),
        .cordic_data_Q(cordic_data_Q), .tx_freq(tx_freq), .rx_phase(rx_phase), .tx_zero(tx_zero),
        .output_strobe(output_strobe), .out_data_I(out_data_I), .out_data_Q(out_data_Q),
        .out_index(out_index), .out_marker(out_marker), .out_short(out_short), .scan_done(scan_done)
    );

    typedef struct {
        int idx; bit marker; bit shrt; bit done; int gap;
        logic [NCH*OUT_W-1:0] di; logic [NCH*OUT_W-1:0] dq; logic [31:0] freq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_vec = 0, n_err = 0;
    int cyc = 0, last_stb = 0;
    int per = 1, vphase = 0;
    int ival[NCH], qval[NCH];
    logic [31:0] prev_tx = '0, prev_rx = '0;
    logic [1:0]  prev_tz = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Mean of ns identical samples, scaled to OUT_W by flooring division.
    function automatic logic [OUT_W-1:0] avg_model(input int v, input int ns);
        longint s;
        s = longint'(v) * longint'(ns);
        s = s >>> SHIFT;
        return s[OUT_W-1:0];
    endfunction

    task automatic push_scan(input logic [31:0] st, input logic [31:0] dl, input int cnt,
                             input bit timed_marker);
        int ns;
        ns = (WINDOW / per < NAVG) ? WINDOW / per : NAVG;
        for (int k = 0; k <= cnt; k++) begin
            exp_t e;
            e.idx    = k;
            e.marker = (k == 0);
            e.done   = (k == cnt);
            e.shrt   = (k != 0) && (ns < NAVG);
            e.freq   = st + dl * 32'((k == 0) ? 0 : k - 1);
            e.gap    = (k == 0 && !timed_marker) ? 0 : CLKS;
            e.di     = '0;
            e.dq     = '0;
            for (int c = 0; c < NCH; c++) begin
                e.di[c*OUT_W +: OUT_W] = (k == 0) ? '0 : avg_model(ival[c], ns);
                e.dq[c*OUT_W +: OUT_W] = (k == 0) ? '0 : avg_model(qval[c], ns);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic set_data();
        for (int c = 0; c < NCH; c++) begin
            cordic_data_I[c*IN_W +: IN_W] = IN_W'(ival[c]);
            cordic_data_Q[c*IN_W +: IN_W] = IN_W'(qval[c]);
        end
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("strobes_outstanding", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_single(input logic [31:0] st, input logic [31:0] dl, input int cnt);
        freq_start = st;
        freq_delta = dl;
        vna_count  = 16'(cnt);
        repeat (2) @(negedge clk);
        scan_start = 1'b1;
        push_scan(st, dl, cnt, 1'b0);
        @(negedge clk);
        scan_start = 1'b0;
        drain((cnt + 2) * CLKS + 50);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx"}, tx_freq, 0);
        chk({tag, "_rx"}, rx_phase, 0);
        chk({tag, "_tz"}, tx_zero, 0);
        chk({tag, "_stb"}, output_strobe, 0);
        chk({tag, "_I"}, out_data_I, 0);
        chk({tag, "_Q"}, out_data_Q, 0);
        chk({tag, "_idx"}, out_index, 0);
        chk({tag, "_mark"}, out_marker, 0);
        chk({tag, "_short"}, out_short, 0);
        chk({tag, "_done"}, scan_done, 0);
    endtask

    // in_valid is periodic; every period used divides the averaging window exactly.
    initial begin
        in_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            vphase++;
            in_valid = (vphase % per) == 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (output_strobe) begin
            chk("strobe_was_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("out_index", out_index, 64'(mon_e.idx));
                chk("out_marker", out_marker, mon_e.marker);
                chk("out_short", out_short, mon_e.shrt);
                chk("scan_done", scan_done, mon_e.done);
                chk("out_data_I", out_data_I, mon_e.di);
                chk("out_data_Q", out_data_Q, mon_e.dq);
                chk("slot_tx_freq", prev_tx, mon_e.freq);
                chk("slot_rx_phase", prev_rx, mon_e.freq);
                chk("slot_tx_zero", prev_tz, {mon_e.freq[31:16] == 16'd0, mon_e.freq[15:0] == 16'd0});
                if (mon_e.gap != 0) chk("strobe_spacing", 64'(cyc - last_stb), 64'(mon_e.gap));
            end
            last_stb = cyc;
        end
        prev_tx = tx_freq;
        prev_rx = rx_phase;
        prev_tz = tx_zero;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int pers[7];
        logic [31:0] st, dl;
        pers = '{1, 2, 3, 4, 6, 8, 16};
        rst_n = 1'b0; vna = 1'b0; scan_start = 1'b0; continuous = 1'b0;
        freq_start = '0; freq_delta = '0; rx_freq_in = '0; vna_count = '0;
        cordic_data_I = '0; cordic_data_Q = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");

        rst_n = 1'b1;
        freq_start = $urandom;
        rx_freq_in = $urandom;
        @(negedge clk);
        chk("normal_tx", tx_freq, freq_start);
        chk("normal_rx", rx_phase, rx_freq_in);

        vna = 1'b1; vna_count = '0; freq_start = 32'h1234_0000;
        repeat (4) @(negedge clk);
        chk("pcscan_tx", tx_freq, 32'h1234_0000);
        chk("pcscan_rx", rx_phase, 32'h1234_0000);
        chk("pcscan_tz", tx_zero, 2'b01);

        for (int c = 0; c < NCH; c++) begin ival[c] = 100; qval[c] = -4; end
        set_data();
        per = 1;
        run_single(32'h0000_1000, 32'h0000_0100, 3);
        per = 8;
        run_single(32'h0000_2000, 32'h0000_0010, 2);

        repeat (5) begin
            for (int c = 0; c < NCH; c++) begin
                ival[c] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
                qval[c] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
            end
            set_data();
            per = pers[$urandom_range(0, 6)];
            st = $urandom;
            dl = $urandom;
            run_single(st, dl, int'($urandom_range(1, 4)));
        end

        per = 1;
        freq_start = 32'h0000_5000; freq_delta = 32'h0000_0040; vna_count = 16'd3;
        @(negedge clk);
        scan_start = 1'b1;
        push_scan(32'h0000_5000, 32'h0000_0040, 3, 1'b0);
        @(negedge clk);
        scan_start = 1'b0;
        repeat (700) @(negedge clk);
        chk("marker_before_reset", 64'(exp_q.size()), 64'd3);
        exp_q.delete();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("midscan_reset");
        rst_n = 1'b1;
        repeat (2 * CLKS + 100) @(negedge clk);

        for (int c = 0; c < NCH; c++) begin
            ival[c] = int'($urandom_range(0, 4000)) - 2000;
            qval[c] = int'($urandom_range(0, 4000)) - 2000;
        end
        set_data();
        freq_start = 32'hFFFF_FF00; freq_delta = 32'h0000_0100; vna_count = 16'd2;
        continuous = 1'b1;
        push_scan(32'hFFFF_FF00, 32'h0000_0100, 2, 1'b0);
        push_scan(32'hFFFF_FF00, 32'h0000_0100, 2, 1'b1);
        drain(8 * CLKS);

        repeat (100) @(negedge clk);
        vna = 1'b0;
        continuous = 1'b0;
        rx_freq_in = $urandom;
        @(negedge clk);
        chk("abort_tx", tx_freq, 32'hFFFF_FF00);
        chk("abort_rx", rx_phase, rx_freq_in);
        repeat (3) @(negedge clk);
        vna = 1'b1;
        repeat (CLKS + 100) @(negedge clk);
        chk("idle_after_abort_no_strobe", 64'(cyc - last_stb > CLKS), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
